cache_mem_arbiter: RTL and testbench

- Sits between the L1 caches and the AXI bridge, and shares one memory port between the icache and the dcache.
- Read channel: arbitrates icache and dcache refill/uncached reads and routes the returned beats back to the owner.
- Write channel: accepts dcache victim-line or uncached writes into a one-entry buffer and serializes them as 32-bit beats.
- Blocks any read that targets the line currently held in the write buffer (read-after-write hazard).

---
 rtl/cache_mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache/dcache reads and a one-entry dcache write buffer.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin read arbitration (default: dcache priority).
module cache_mem_arbiter #(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ic_rd_req,
   input  logic [2:0]               ic_rd_type,
   input  logic [ADDR_W-1:0]        ic_rd_addr,
   output logic                     ic_rd_rdy,
   output logic                     ic_ret_valid,
   output logic                     ic_ret_last,
   output logic [31:0]              ic_ret_data,
   input  logic                     dc_rd_req,
   input  logic [2:0]               dc_rd_type,
   input  logic [ADDR_W-1:0]        dc_rd_addr,
   output logic                     dc_rd_rdy,
   output logic                     dc_ret_valid,
   output logic                     dc_ret_last,
   output logic [31:0]              dc_ret_data,
   input  logic                     dc_wr_req,
   input  logic [2:0]               dc_wr_type,
   input  logic [ADDR_W-1:0]        dc_wr_addr,
   input  logic [3:0]               dc_wr_wstrb,
   input  logic [LINE_WORDS*32-1:0] dc_wr_data,
   output logic                     dc_wr_rdy,
   output logic                     m_rd_req,
   output logic [ADDR_W-1:0]        m_rd_addr,
   output logic [1:0]               m_rd_len,
   output logic [2:0]               m_rd_size,
   input  logic                     m_rd_rdy,
   input  logic                     m_ret_valid,
   input  logic                     m_ret_last,
   input  logic [31:0]              m_ret_data,
   output logic                     m_wr_req,
   output logic [ADDR_W-1:0]        m_wr_addr,
   output logic [1:0]               m_wr_len,
   output logic [2:0]               m_wr_size,
   input  logic                     m_wr_rdy,
   output logic                     m_wdata_valid,
   output logic [31:0]              m_wdata,
   output logic [3:0]               m_wstrb,
   output logic                     m_wdata_last,
   input  logic                     m_wdata_rdy,
   input  logic                     m_wr_done
);
   localparam logic [1:0] LINE_LEN = 2'(LINE_WORDS - 1);

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

   function automatic logic is_line(input logic [2:0] t);
      return t == 3'b100;
   endfunction

   function automatic logic [1:0] xfer_len(input logic [2:0] t);
      return is_line(t) ? LINE_LEN : 2'd0;
   endfunction

   // Unknown type codes fall back to a single word beat.
   function automatic logic [2:0] xfer_size(input logic [2:0] t);
      case (t)
         3'b000, 3'b001, 3'b010: return t;
         default:                return 3'b010;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] xfer_addr(input logic [ADDR_W-1:0] a, input logic [2:0] t);
      return is_line(t) ? {a[ADDR_W-1:4], 4'h0} : a;
   endfunction

   rd_state_t                r_rd_state, w_rd_next;
   wr_state_t                r_wr_state, w_wr_next;
   logic                     r_rd_own_dc;
   logic [ADDR_W-1:0]        r_rd_addr;
   logic [1:0]               r_rd_len;
   logic [2:0]               r_rd_size;
   logic [ADDR_W-1:0]        r_wbuf_addr;
   logic [2:0]               r_wbuf_type;
   logic [3:0]               r_wbuf_strb;
   logic [LINE_WORDS*32-1:0] r_wbuf_data;
   logic [1:0]               r_wr_cnt;
   logic                     w_wr_accept, w_ic_haz, w_dc_haz, w_ic_elig, w_dc_elig;
   logic                     w_pick_dc, w_pick_ic, w_rd_accept, w_beat_last;
   logic [1:0]               w_wsel;
   logic [6:0]               w_wbit;
   logic [ADDR_W-1:0]        w_win_addr;
   logic [2:0]               w_win_type;

   assign w_wr_accept = dc_wr_req && (r_wr_state == W_IDLE) && rst_n;

   // A read is held off while its line is in, or entering, the write buffer.
   assign w_ic_haz = ((r_wr_state != W_IDLE) && (ic_rd_addr[ADDR_W-1:4] == r_wbuf_addr[ADDR_W-1:4])) ||
                     (w_wr_accept && (ic_rd_addr[ADDR_W-1:4] == dc_wr_addr[ADDR_W-1:4]));
   assign w_dc_haz = ((r_wr_state != W_IDLE) && (dc_rd_addr[ADDR_W-1:4] == r_wbuf_addr[ADDR_W-1:4])) ||
                     (w_wr_accept && (dc_rd_addr[ADDR_W-1:4] == dc_wr_addr[ADDR_W-1:4]));
   assign w_ic_elig = ic_rd_req && !w_ic_haz;
   assign w_dc_elig = dc_rd_req && !w_dc_haz;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_dc;
   always_ff @(posedge clk) begin
      if (!rst_n)           r_last_dc <= 1'b0;
      else if (w_rd_accept) r_last_dc <= w_pick_dc;
   end
   assign w_pick_dc = w_dc_elig && !(w_ic_elig && r_last_dc);
`else
   assign w_pick_dc = w_dc_elig;
`endif
   assign w_pick_ic   = w_ic_elig && !w_pick_dc;
   assign w_rd_accept = (r_rd_state == R_IDLE) && rst_n && (w_dc_elig || w_ic_elig);
   assign w_win_addr  = w_pick_dc ? dc_rd_addr : ic_rd_addr;
   assign w_win_type  = w_pick_dc ? dc_rd_type : ic_rd_type;

   always_ff @(posedge clk) begin
      if (!rst_n) r_rd_state <= R_IDLE;
      else        r_rd_state <= w_rd_next;
   end

   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (w_rd_accept) w_rd_next = R_REQ;
         R_REQ:   if (m_rd_rdy) w_rd_next = R_DATA;
         R_DATA:  if (m_ret_valid && m_ret_last) w_rd_next = R_IDLE;
         default: w_rd_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_rd_accept) begin
         r_rd_own_dc <= w_pick_dc;
         r_rd_addr   <= xfer_addr(w_win_addr, w_win_type);
         r_rd_len    <= xfer_len(w_win_type);
         r_rd_size   <= xfer_size(w_win_type);
      end
   end

   always_comb begin
      ic_rd_rdy    = w_rd_accept && w_pick_ic;
      dc_rd_rdy    = w_rd_accept && w_pick_dc;
      m_rd_req     = 1'b0;
      m_rd_addr    = '0;
      m_rd_len     = '0;
      m_rd_size    = '0;
      ic_ret_valid = 1'b0;
      ic_ret_last  = 1'b0;
      ic_ret_data  = '0;
      dc_ret_valid = 1'b0;
      dc_ret_last  = 1'b0;
      dc_ret_data  = '0;
      case (r_rd_state)
         R_REQ: begin
            m_rd_req  = 1'b1;
            m_rd_addr = r_rd_addr;
            m_rd_len  = r_rd_len;
            m_rd_size = r_rd_size;
         end
         R_DATA: begin
            if (r_rd_own_dc) begin
               dc_ret_valid = m_ret_valid;
               dc_ret_last  = m_ret_last;
               dc_ret_data  = m_ret_data;
            end else begin
               ic_ret_valid = m_ret_valid;
               ic_ret_last  = m_ret_last;
               ic_ret_data  = m_ret_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_wr_state <= W_IDLE;
      else        r_wr_state <= w_wr_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                                   r_wr_cnt <= '0;
      else if (r_wr_state == W_ADDR)                r_wr_cnt <= '0;
      else if (r_wr_state == W_DATA && m_wdata_rdy) r_wr_cnt <= r_wr_cnt + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_wbuf_addr <= dc_wr_addr;
         r_wbuf_type <= dc_wr_type;
         r_wbuf_strb <= dc_wr_wstrb;
         r_wbuf_data <= dc_wr_data;
      end
   end

   assign w_beat_last = (r_wr_cnt == xfer_len(r_wbuf_type));
   assign w_wsel      = is_line(r_wbuf_type) ? r_wr_cnt : r_wbuf_addr[3:2];
   assign w_wbit      = {w_wsel, 5'd0};

   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         W_IDLE:  if (w_wr_accept) w_wr_next = W_ADDR;
         W_ADDR:  if (m_wr_rdy) w_wr_next = W_DATA;
         W_DATA:  if (m_wdata_rdy && w_beat_last) w_wr_next = W_RESP;
         W_RESP:  if (m_wr_done) w_wr_next = W_IDLE;
         default: w_wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      dc_wr_rdy     = (r_wr_state == W_IDLE) && rst_n;
      m_wr_req      = 1'b0;
      m_wr_addr     = '0;
      m_wr_len      = '0;
      m_wr_size     = '0;
      m_wdata_valid = 1'b0;
      m_wdata       = '0;
      m_wstrb       = '0;
      m_wdata_last  = 1'b0;
      case (r_wr_state)
         W_ADDR: begin
            m_wr_req  = 1'b1;
            m_wr_addr = xfer_addr(r_wbuf_addr, r_wbuf_type);
            m_wr_len  = xfer_len(r_wbuf_type);
            m_wr_size = xfer_size(r_wbuf_type);
         end
         W_DATA: begin
            m_wdata_valid = 1'b1;
            m_wdata       = r_wbuf_data[w_wbit +: 32];
            m_wstrb       = is_line(r_wbuf_type) ? 4'hF : r_wbuf_strb;
            m_wdata_last  = w_beat_last;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: requester/memory stubs plus a transaction-level model.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
   logic [2:0]   ic_rd_type;
   logic [31:0]  ic_rd_addr, ic_ret_data;
   logic         dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
   logic [2:0]   dc_rd_type;
   logic [31:0]  dc_rd_addr, dc_ret_data;
   logic         dc_wr_req, dc_wr_rdy;
   logic [2:0]   dc_wr_type;
   logic [31:0]  dc_wr_addr;
   logic [3:0]   dc_wr_wstrb;
   logic [127:0] dc_wr_data;
   logic         m_rd_req, m_rd_rdy, m_ret_valid, m_ret_last;
   logic [31:0]  m_rd_addr, m_ret_data;
   logic [1:0]   m_rd_len;
   logic [2:0]   m_rd_size;
   logic         m_wr_req, m_wr_rdy, m_wdata_valid, m_wdata_last, m_wdata_rdy, m_wr_done;
   logic [31:0]  m_wr_addr, m_wdata;
   logic [1:0]   m_wr_len;
   logic [2:0]   m_wr_size;
   logic [3:0]   m_wstrb;
   logic         any_out;

   cache_mem_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
      .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
      .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
      .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
      .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
      .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
      .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len), .m_rd_size(m_rd_size),
      .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
      .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_len(m_wr_len), .m_wr_size(m_wr_size),
      .m_wr_rdy(m_wr_rdy), .m_wdata_valid(m_wdata_valid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wdata_last(m_wdata_last), .m_wdata_rdy(m_wdata_rdy), .m_wr_done(m_wr_done)
   );

   assign any_out = |{ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
                      dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data, dc_wr_rdy,
                      m_rd_req, m_rd_addr, m_rd_len, m_rd_size,
                      m_wr_req, m_wr_addr, m_wr_len, m_wr_size,
                      m_wdata_valid, m_wdata, m_wstrb, m_wdata_last};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_len(input logic [2:0] t);
      return (t == 3'd4) ? 2'd3 : 2'd0;
   endfunction
   function automatic logic [2:0] exp_size(input logic [2:0] t);
      return (t < 3'd3) ? t : 3'd2;
   endfunction
   function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [2:0] t);
      return (t == 3'd4) ? (a & 32'hFFFF_FFF0) : a;
   endfunction

   // Small line pool so reads regularly collide with the buffered write.
   function automatic logic [31:0] pick_addr();
      logic [31:0] base;
      case ($urandom_range(0, 5))
         0:       base = 32'h1000_0040;
         1:       base = 32'h2000_0010;
         2:       base = 32'h3000_0000;
         3:       base = 32'h4000_0000;
         4:       base = 32'h5000_0020;
         default: base = 32'h6000_0080;
      endcase
      return base | 32'($urandom_range(0, 15));
   endfunction

   task automatic clear_inputs();
      ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
      dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
      dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
      m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
      m_wr_rdy = 0; m_wdata_rdy = 0; m_wr_done = 0;
   endtask

   // Reference model state: read channel phase (0 idle,1 req,2 data), write phase (0..3).
   int          rph, wph, r_beats, rcnt;
   logic        r_own_dc, last_dc, ic_pend, dc_pend, wr_pend, sat, reset_done;
   logic [31:0] r_addr, w_addr;
   logic [1:0]  r_len;
   logic [2:0]  r_size, w_type;
   logic [36:0] wq[$];
   logic        g_seq[$];
   int          n_rd_done, n_wr_done, n_rd_after_rst;

   initial begin
      logic ic_el, dc_el, g_ic, g_dc, wacc, ic_haz, dc_haz, exp_icv, exp_dcv;
      rph = 0; wph = 0; r_beats = 0; rcnt = 0; last_dc = 0;
      ic_pend = 0; dc_pend = 0; wr_pend = 0; reset_done = 0;
      r_own_dc = 0; r_addr = 0; r_len = 0; r_size = 0; w_addr = 0; w_type = 0;
      n_rd_done = 0; n_wr_done = 0; n_rd_after_rst = 0;
      rst_n = 1'b0;
      clear_inputs();
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs", 64'(any_out), 64'd0);

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (rcnt == 0 && !reset_done && cyc >= 2000 && rph == 2 && r_len == 2'd3 && r_beats == 3)
            rcnt = 2;
         if (rcnt > 0) begin
            rst_n = 1'b0;
            clear_inputs();
            if (rcnt == 2) begin
               rph = 0; wph = 0; last_dc = 0; ic_pend = 0; dc_pend = 0; wr_pend = 0;
               wq.delete();
               reset_done = 1;
            end else begin
               ic_rd_req = 1; dc_rd_req = 1; dc_wr_req = 1;
               m_ret_valid = 1; m_ret_last = 1; m_wr_done = 1;
               #1;
               check("mid_reset_outs", 64'(any_out), 64'd0);
            end
            rcnt--;
            continue;
         end
         rst_n = 1'b1;
         sat = (g_seq.size() < 4) && (cyc < 300);

         // memory-side stub
         m_rd_rdy   = (rph == 1) && ($urandom_range(0, 1) == 0);
         m_ret_data = $urandom;
         if (rph == 2) begin
            m_ret_valid = ($urandom_range(0, 4) < 3);
            m_ret_last  = m_ret_valid && (r_beats == 1);
         end else begin
            m_ret_valid = ($urandom_range(0, 9) == 0);
            m_ret_last  = 1'($urandom_range(0, 1));
         end
         m_wr_rdy    = (wph == 1) && ($urandom_range(0, 1) == 0);
         m_wdata_rdy = (wph == 2) && ($urandom_range(0, 4) < 3);
         m_wr_done   = (wph == 3) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 9) == 0);

         // cache-side requesters hold each request until accepted
         if (!ic_pend && (sat || $urandom_range(0, 3) == 0)) begin
            ic_pend = 1; ic_rd_addr = pick_addr();
            ic_rd_type = sat ? 3'd4 : 3'($urandom_range(0, 7));
         end
         if (!dc_pend && (sat || $urandom_range(0, 3) == 0)) begin
            dc_pend = 1; dc_rd_addr = pick_addr();
            dc_rd_type = sat ? 3'd4 : 3'($urandom_range(0, 7));
         end
         if (!wr_pend && !sat && $urandom_range(0, 5) == 0) begin
            wr_pend = 1; dc_wr_addr = pick_addr(); dc_wr_type = 3'($urandom_range(0, 7));
            dc_wr_wstrb = 4'($urandom_range(0, 15));
            dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
         end
         ic_rd_req = ic_pend;
         dc_rd_req = dc_pend;
         dc_wr_req = wr_pend;
         #1;

         // expected grant from the arbitration rules
         wacc   = wr_pend && (wph == 0);
         ic_haz = (wph != 0 && ic_rd_addr[31:4] == w_addr[31:4]) || (wacc && ic_rd_addr[31:4] == dc_wr_addr[31:4]);
         dc_haz = (wph != 0 && dc_rd_addr[31:4] == w_addr[31:4]) || (wacc && dc_rd_addr[31:4] == dc_wr_addr[31:4]);
         ic_el  = ic_pend && !ic_haz && (rph == 0);
         dc_el  = dc_pend && !dc_haz && (rph == 0);
`ifdef ARB_ROUND_ROBIN_EN
         g_dc = (ic_el && dc_el) ? !last_dc : dc_el;
`else
         g_dc = dc_el;
`endif
         g_ic = ic_el && !g_dc;
         exp_icv = (rph == 2) && !r_own_dc && m_ret_valid;
         exp_dcv = (rph == 2) && r_own_dc && m_ret_valid;

         check("rd_rdy", 64'({ic_rd_rdy, dc_rd_rdy}), 64'({g_ic, g_dc}));
         check("m_rd_req", 64'(m_rd_req), 64'(rph == 1));
         if (rph == 1)
            check("m_rd_fields", 64'({m_rd_addr, m_rd_len, m_rd_size}), 64'({r_addr, r_len, r_size}));
         check("ret_valid", 64'({ic_ret_valid, dc_ret_valid}), 64'({exp_icv, exp_dcv}));
         if (exp_icv) check("ic_ret_beat", 64'({ic_ret_last, ic_ret_data}), 64'({m_ret_last, m_ret_data}));
         if (exp_dcv) check("dc_ret_beat", 64'({dc_ret_last, dc_ret_data}), 64'({m_ret_last, m_ret_data}));
         check("dc_wr_rdy", 64'(dc_wr_rdy), 64'(wph == 0));
         check("m_wr_req", 64'(m_wr_req), 64'(wph == 1));
         if (wph == 1)
            check("m_wr_fields", 64'({m_wr_addr, m_wr_len, m_wr_size}),
                  64'({exp_addr(w_addr, w_type), exp_len(w_type), exp_size(w_type)}));
         check("m_wdata_valid", 64'(m_wdata_valid), 64'(wph == 2));
         if (wph == 2 && wq.size() > 0)
            check("wr_beat", 64'({m_wdata, m_wstrb, m_wdata_last}), 64'(wq[0]));
         if (sat && (ic_rd_rdy || dc_rd_rdy)) g_seq.push_back(dc_rd_rdy);

         // advance the model across the coming clock edge
         if (g_ic || g_dc) begin
            rph = 1; r_own_dc = g_dc; last_dc = g_dc;
            r_addr = exp_addr(g_dc ? dc_rd_addr : ic_rd_addr, g_dc ? dc_rd_type : ic_rd_type);
            r_len  = exp_len(g_dc ? dc_rd_type : ic_rd_type);
            r_size = exp_size(g_dc ? dc_rd_type : ic_rd_type);
            if (g_dc) dc_pend = 0; else ic_pend = 0;
         end else if (rph == 1 && m_rd_rdy) begin
            rph = 2; r_beats = r_len + 1;
         end else if (rph == 2 && m_ret_valid) begin
            r_beats--;
            if (r_beats == 0) begin
               rph = 0; n_rd_done++;
               if (reset_done) n_rd_after_rst++;
            end
         end
         if (wacc) begin
            w_addr = dc_wr_addr; w_type = dc_wr_type; wr_pend = 0; wph = 1;
            if (dc_wr_type == 3'd4) begin
               for (int i = 0; i < 4; i++) wq.push_back({dc_wr_data[32*i +: 32], 4'hF, i == 3});
            end else begin
               wq.push_back({dc_wr_data[32*int'(dc_wr_addr[3:2]) +: 32], dc_wr_wstrb, 1'b1});
            end
         end else if (wph == 1 && m_wr_rdy) begin
            wph = 2;
         end else if (wph == 2 && m_wdata_rdy) begin
            void'(wq.pop_front());
            if (wq.size() == 0) wph = 3;
         end else if (wph == 3 && m_wr_done) begin
            wph = 0; n_wr_done++;
         end
      end

      check("sat_grants", 64'(g_seq.size()), 64'd4);
      for (int i = 0; i < g_seq.size() && i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         check("grant_order", 64'(g_seq[i]), 64'(i % 2 == 0));
`else
         check("grant_order", 64'(g_seq[i]), 64'd1);
`endif
      end
      check("reset_hit", 64'(reset_done), 64'd1);
      check("rd_progress", 64'(n_rd_done > 30), 64'd1);
      check("wr_progress", 64'(n_wr_done > 10), 64'd1);
      check("rd_after_reset", 64'(n_rd_after_rst > 0), 64'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
